// File: rtl/spi_mbox_n.sv
// spi_mbox_n: SPI-slave (mode 0) mailbox between a host MCU and the Z80 I/O side.
// Two DEPTH-entry byte arrays are exchanged.
// - spi_to_z80 is written by the host and read by the Z80.
// - z80_to_spi is written by the Z80 and read by the host.
// The SPI pins are oversampled by clk through 2-flop synchronisers.
// Each frame starts with a command byte:
// - bit 7 is the direction (1 = host write).
// - the low AW bits are the starting slot.
`timescale 1ns/1ps

module spi_mbox_n #(
    parameter int          DEPTH = 8,
    parameter int          AW    = $clog2(DEPTH),  // derived from DEPTH; leave at default
    parameter logic [7:0]  SIG   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sck,
    input  logic              spi_ss,
    input  logic              spi_si,
    output logic              spi_so,
    output logic              spi_so_oe,
    input  logic [AW-1:0]     z80_addr,
    input  logic              z80_wr,
    input  logic              z80_rd,
    input  logic [7:0]        z80_wdata,
    output logic [7:0]        z80_rdata,
    output logic [DEPTH-1:0]  rx_valid,
    output logic              spi_irq,
    output logic              frame_active
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    // Synchronisers. Index 2 is the extra stage used only for edge detection.
    logic [2:0]         r_sck_sync;
    logic [2:0]         r_ss_sync;
    logic [1:0]         r_si_sync;

    logic               w_sck_rise;
    logic               w_sck_fall;
    logic               w_ss_fall;
    logic               w_ss_rise;
    logic               w_si;

    // Shift datapath
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_rx_shift;
    logic [7:0]         r_tx_shift;
    logic               r_tx_loaded;
    logic               r_so;
    logic               r_dir;
    logic [AW-1:0]      r_ptr;

    // Storage
    logic [7:0]         r_s2z [DEPTH];
    logic [7:0]         r_z2s [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [7:0]         r_rdata;

    // Decoded FSM outputs and datapath strobes
    logic               w_active;
    logic               w_in_cmd;
    logic               w_in_data;
    logic               w_start;
    logic               w_bit_ok;
    logic               w_byte_done;
    logic               w_cmd_done;
    logic               w_data_done;
    logic               w_commit;
    logic [7:0]         w_rx_byte;
    logic [AW-1:0]      w_cmd_ptr;
    logic [AW-1:0]      w_ptr_inc;

    // Bring the asynchronous SPI pins into the clk domain.
    // ss resets low, so a falling edge can only be seen once ss has been observed high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync <= 3'b000;
            r_ss_sync  <= 3'b000;
            r_si_sync  <= 2'b00;
        end else begin
            r_sck_sync <= {r_sck_sync[1:0], spi_sck};
            r_ss_sync  <= {r_ss_sync[1:0],  spi_ss};
            r_si_sync  <= {r_si_sync[0],    spi_si};
        end
    end

    assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
    assign w_sck_fall = ~r_sck_sync[1] & r_sck_sync[2];
    assign w_ss_fall  = ~r_ss_sync[1] & r_ss_sync[2];
    assign w_ss_rise  = r_ss_sync[1] & ~r_ss_sync[2];
    // si has the same synchroniser depth as sck, so it lines up with w_sck_rise.
    assign w_si       = r_si_sync[1];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    // A rising ss always aborts the frame back to IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ss_fall) begin
                    w_state_next = S_CMD;
                end
            end
            S_CMD: begin
                if (w_ss_rise) begin
                    w_state_next = S_IDLE;
                end else if (w_sck_rise && (r_bit_cnt == 3'd7)) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_ss_rise) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // FSM output decode
    always_comb begin
        w_active  = 1'b0;
        w_in_cmd  = 1'b0;
        w_in_data = 1'b0;
        case (r_state)
            S_CMD: begin
                w_active = 1'b1;
                w_in_cmd = 1'b1;
            end
            S_DATA: begin
                w_active  = 1'b1;
                w_in_data = 1'b1;
            end
            default: begin
                w_active = 1'b0;
            end
        endcase
    end

    assign w_start     = (r_state == S_IDLE) & w_ss_fall;
    assign w_bit_ok    = w_active & ~w_ss_rise & w_sck_rise;
    assign w_byte_done = w_bit_ok & (r_bit_cnt == 3'd7);
    assign w_cmd_done  = w_byte_done & w_in_cmd;
    assign w_data_done = w_byte_done & w_in_data;
    assign w_commit    = w_data_done & r_dir;
    assign w_rx_byte   = {r_rx_shift[6:0], w_si};
    assign w_cmd_ptr   = w_rx_byte[AW-1:0];
    assign w_ptr_inc   = r_ptr + AW'(1);

    // Shift datapath.
    // - Receive on sck rise and transmit on sck fall.
    // - Decode the command byte and advance the slot pointer.
    // - r_tx_loaded makes the first fall after a byte load present bit 7 of the
    //   new byte instead of shifting it away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= 3'd0;
            r_rx_shift  <= 8'h00;
            r_tx_shift  <= 8'h00;
            r_tx_loaded <= 1'b0;
            r_so        <= 1'b0;
            r_dir       <= 1'b0;
            r_ptr       <= '0;
        end else if (w_start) begin
            r_bit_cnt   <= 3'd0;
            r_rx_shift  <= 8'h00;
            r_tx_shift  <= SIG;
            r_tx_loaded <= 1'b0;
            r_so        <= SIG[7];
        end else if (w_active && w_ss_rise) begin
            r_so        <= 1'b0;
            r_tx_loaded <= 1'b0;
        end else if (w_active) begin
            if (w_sck_rise) begin
                r_rx_shift <= w_rx_byte;
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                if (w_cmd_done) begin
                    r_dir <= w_rx_byte[7];
                    r_ptr <= w_cmd_ptr;
                    if (!w_rx_byte[7]) begin
                        r_tx_shift  <= r_z2s[w_cmd_ptr];
                        r_tx_loaded <= 1'b1;
                    end
                end else if (w_data_done) begin
                    r_ptr <= w_ptr_inc;
                    if (!r_dir) begin
                        r_tx_shift  <= r_z2s[w_ptr_inc];
                        r_tx_loaded <= 1'b1;
                    end
                end
            end else if (w_sck_fall) begin
                if (r_tx_loaded) begin
                    r_so        <= r_tx_shift[7];
                    r_tx_loaded <= 1'b0;
                end else begin
                    r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                    r_so       <= r_tx_shift[6];
                end
            end
        end
    end

    // Z80-written array.
    // A host read samples this array with the old contents when a z80_wr lands in the same clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_z2s[i] <= 8'h00;
            end
        end else if (z80_wr) begin
            r_z2s[z80_addr] <= z80_wdata;
        end
    end

    // Host-written array, new-data flags and the Z80 read port.
    // The SPI set is placed after the Z80 clear, so the set wins on a same-slot collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_s2z[i] <= 8'h00;
            end
            r_valid <= '0;
            r_rdata <= 8'h00;
        end else begin
            if (z80_rd) begin
                r_rdata           <= r_s2z[z80_addr];
                r_valid[z80_addr] <= 1'b0;
            end
            if (w_commit) begin
                r_s2z[r_ptr]   <= w_rx_byte;
                r_valid[r_ptr] <= 1'b1;
            end
        end
    end

    assign spi_so       = r_so;
    assign spi_so_oe    = w_active;
    assign frame_active = w_active;
    assign z80_rdata    = r_rdata;
    assign rx_valid     = r_valid;
    assign spi_irq      = |r_valid;

endmodule

// File: doc/spi_mbox_n.md
Name: spi_mbox_n

Overview:
Parametrised SPI-slave mailbox between an external SPI master (the host MCU) and the Z80 I/O side. It holds two DEPTH-entry byte arrays: spi_to_z80, written over SPI and read by the Z80, and z80_to_spi, written by the Z80 and read over SPI. The SPI slave is implemented in fabric with oversampling, and each frame is addressed by a command byte. Per-slot "new data" flags and an interrupt tell the Z80 side when SPI has written a slot.

Parameters:
DEPTH, 8, entries per direction; must be a power of two, 2..128.
AW, $clog2(DEPTH), slot index width; derived, not overridden.
SIG, 8'hA5, byte shifted out on SO during the command byte.

Ports:
clk  in  1  system clock; must be at least 8x spi_sck frequency.
rst_n  in  1  asynchronous active-low reset.
spi_sck  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0); asynchronous to clk.
spi_ss  in  1  SPI chip select, active low; asynchronous to clk.
spi_si  in  1  MOSI.
spi_so  out  1  MISO, MSB first.
spi_so_oe  out  1  MISO output enable; high while the frame is active.
z80_addr  in  AW  slot index for Z80 access.
z80_wr  in  1  one-clk strobe: z80_to_spi[z80_addr] <= z80_wdata.
z80_rd  in  1  one-clk strobe: read spi_to_z80[z80_addr] and clear its flag.
z80_wdata  in  8  Z80 write data.
z80_rdata  out  8  registered read data.
rx_valid  out  DEPTH  per-slot new-data flags.
spi_irq  out  1  OR of rx_valid.
frame_active  out  1  synchronised, inverted spi_ss.

Behaviour:
- Reset (async, rst_n low):
  - Both arrays clear to 0; rx_valid, z80_rdata, spi_irq and frame_active go to 0.
  - spi_so and spi_so_oe go to 0; the FSM goes to IDLE.
- Synchronisers:
  - spi_sck, spi_ss and spi_si each pass through a 2-flop synchroniser.
  - Edges of sck are detected from the 3rd stage versus the 2nd stage.
  - The sampling of si is aligned to the detected sck rising edge.
- FSM states: IDLE, CMD, DATA.
  - IDLE -> CMD on synchronised ss falling. At that transition: bit counter = 0, tx shift register loads SIG, spi_so = SIG[7].
  - CMD: each sck rise shifts si into rx_shift. Each sck fall shifts tx_shift left and drives spi_so = new MSB.
  - CMD, at the 8th rise: latch dir = cmd[7] (1 = host write, 0 = host read) and ptr = cmd[AW-1:0]; other bits are ignored. If dir = 0, load tx_shift with z80_to_spi[ptr] in the same clk. Go to DATA.
  - DATA, host write: at each 8th rise, commit spi_to_z80[ptr] <= rx byte and set rx_valid[ptr]; then ptr <= ptr + 1, wrapping mod DEPTH.
  - DATA, host read: at each 8th rise, ptr <= ptr + 1 (mod DEPTH) and tx_shift loads z80_to_spi[ptr+1]. The first sck fall after the load outputs bit 7 of the new byte.
  - Any state -> IDLE on synchronised ss rising. A partially shifted byte is discarded, with no commit and no flag set. spi_so_oe goes to 0.
- Host read data is sampled at the byte-load clk. A z80_wr to the same slot in that same clk is not seen this frame; the old value is sent.
- Z80 side:
  - z80_wr takes effect at the next clk edge.
  - z80_rd: z80_rdata is valid 1 clk after the strobe and holds until the next z80_rd.
  - z80_rd clears rx_valid[z80_addr] at the same edge.
- Simultaneous SPI commit and z80_rd to the same slot in one clk:
  - The set wins; rx_valid stays 1.
  - z80_rdata returns the old value.
- Latency: an SPI commit appears in rx_valid and spi_irq 1 clk after the commit edge, and is readable from the next clk.
- frame_active follows the synchronised ss and is high from the IDLE->CMD clk until the ->IDLE clk.
- A frame with 0 data bytes (command only) changes no state other than the FSM.
- Deasserting rst_n mid-frame aborts the frame. After reset release, the FSM waits for a fresh ss falling edge; if ss is low at release, the FSM stays in IDLE until ss has been seen high and then low.

Test Plan:
- Reset, then a read frame cmd 8'h00 plus 2 bytes with no Z80 writes -> SO returns A5, 00, 00; rx_valid = 0; spi_irq = 0.
- Host write cmd 8'h86 with data 11, 22, 33 (DEPTH = 8) -> slots 6, 7, 0 = 11, 22, 33 (wrap); rx_valid = 8'hC1; spi_irq = 1.
- Z80 writes z80_to_spi[3..5] = 3C, 4D, 5E, then host read cmd 8'h03 plus 3 bytes -> SO returns A5, 3C, 4D, 5E; spi_so_oe = 0 after ss rises.
- After the write test: z80_rd addr 6 -> z80_rdata = 11 one clk later and rx_valid = 8'h81. Then force an SPI commit to slot 7 in the same clk as z80_rd addr 7 -> rx_valid[7] stays 1.
- Host write cmd 8'h82 with a full byte 99, then 4 bits of a second byte, then ss high -> slot 2 = 99 and slot 3 unchanged; rx_valid gains bit 2 only.
- Assert rst_n mid-frame with ss held low, release, clock 16 sck -> no commits, spi_so = 0, FSM in IDLE. Then raise and lower ss -> a normal frame works.
